mem_requester: RTL and testbench
================================

# mem_requester

Initiator-side controller for the dummy `memory` block's req/wr/memBusy protocol. It accepts single read or write commands from an upstream valid/ready port and drives `memAddr`/`memDataIn`/`wr`/`req` to the memory. It tracks `memBusy` to completion, captures read data, and returns one response per command. It is the component every bus master in the SoC uses in place of a hand-driven stimulus process.

## Interface
Parameters:
- MEM_ADDR_SIZE, 32, address width
- MEM_WORD_SIZE, 8, data word width
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-low reset
- cmdValid  in  1  command present
- cmdReady  out  1  command accepted when cmdValid && cmdReady
- cmdWr  in  1  1 = write, 0 = read
- cmdAddr  in  MEM_ADDR_SIZE  command address
- cmdData  in  MEM_WORD_SIZE  write data
- rspValid  out  1  response present
- rspReady  in  1  response consumed when rspValid && rspReady
- rspData  out  MEM_WORD_SIZE  read data; 0 for writes and errors
- rspErr  out  1  1 = watchdog timeout
- memAddr  out  MEM_ADDR_SIZE  to memory
- memDataIn  out  MEM_WORD_SIZE  to memory
- wr  out  1  to memory
- req  out  1  to memory; one-cycle request pulse
- memBusy  in  1  from memory
- memDataOut  in  MEM_WORD_SIZE  from memory

## Operation
- States: IDLE, REQ, ACK, BUSY, RESP. One command outstanding at a time.
- IDLE: cmdReady = !memBusy. On accept, register cmdWr/cmdAddr/cmdData into memAddr/wr/memDataIn, then go to REQ.
- REQ: req=1 for exactly one cycle, then go to ACK.
- ACK: wait for memBusy=1, then go to BUSY. req stays 0.
- BUSY: wait for memBusy=0. On the first edge sampling memBusy=0, latch rspData = wr ? 0 : memDataOut, then go to RESP.
- RESP: rspValid=1, with rspData/rspErr stable until rspReady. On handshake, go to IDLE.
- memAddr, memDataIn and wr hold their values from accept until the next accept. They never change while the memory is busy.
- Reset values: state IDLE, cmdReady 0 (1 from the first edge after release if memBusy=0), rspValid 0, rspData 0, rspErr 0, req 0, wr 0, memAddr 0, memDataIn 0. The watchdog counter resets to 0.
- Reset mid-transaction: everything above is forced immediately. A memory still busy blocks cmdReady until memBusy falls, and no stale response is produced.
- cmdValid while not in IDLE is ignored (cmdReady=0). A rspReady with no rspValid has no effect.

## Timing
- Accept at edge T0. req is high from T0 to T1. The earliest memBusy sample is at T2.
- With memory busy for L cycles starting at T2, data is latched at edge T2+L. rspValid is high from T2+L.
- Minimum command-to-response is 3+L edges. Back-to-back throughput is one command per 4+L cycles (the RESP handshake cycle plus the IDLE accept cycle).
- rspValid never deasserts without a handshake.
- Watchdog counter: cleared at accept, increments every cycle in ACK or BUSY, saturating width is clog2(TIMEOUT_CYCLES+1).

## Configuration
- MEM_TIMEOUT_EN defined:
  - If the counter reaches TIMEOUT_CYCLES in ACK or BUSY, go to RESP with rspErr=1 and rspData=0.
  - memBusy is then ignored until IDLE, where cmdReady still waits for memBusy=0.
- MEM_TIMEOUT_EN undefined:
  - No counter is built, and ACK and BUSY wait indefinitely.
  - rspErr is tied to 0.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Write A=0x3, D=0xA5, memory latency 2: exactly one req pulse; memAddr=3, memDataIn=0xA5, wr=1 stable through busy; rspValid=1, rspData=0, rspErr=0.
- Fill addresses 0..14 with random data, then read back 0..14: each rspData equals the written byte, and no command is accepted while rspValid=1.
- Hold rspReady=0 for 5 cycles after a read of 0x5A: rspValid and rspData=0x5A stay stable, cmdReady=0 throughout, and cmdReady=1 the cycle after the handshake.
- Pull reset low during BUSY with memBusy still high: all outputs go to 0 immediately. After release, cmdReady stays 0 until memBusy=0.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, a memory that never asserts memBusy: rspValid=1, rspErr=1 and rspData=0 exactly 8 cycles after entering ACK.
- Without MEM_TIMEOUT_EN, the same stuck memory gives no response after 1000 cycles and rspErr is always 0.

Source files
------------

// File: rtl/mem_requester.sv
// Single-outstanding initiator for the memory req/wr/memBusy protocol.
// Optional watchdog timeout enabled by defining MEM_TIMEOUT_EN.
module mem_requester #(
  parameter int MEM_ADDR_SIZE  = 32,
  parameter int MEM_WORD_SIZE  = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmdValid,
  output logic                     cmdReady,
  input  logic                     cmdWr,
  input  logic [MEM_ADDR_SIZE-1:0] cmdAddr,
  input  logic [MEM_WORD_SIZE-1:0] cmdData,
  output logic                     rspValid,
  input  logic                     rspReady,
  output logic [MEM_WORD_SIZE-1:0] rspData,
  output logic                     rspErr,
  output logic [MEM_ADDR_SIZE-1:0] memAddr,
  output logic [MEM_WORD_SIZE-1:0] memDataIn,
  output logic                     wr,
  output logic                     req,
  input  logic                     memBusy,
  input  logic [MEM_WORD_SIZE-1:0] memDataOut
);

  typedef enum logic [2:0] {IDLE, REQ, ACK, BUSY, RESP} state_t;

  state_t state, state_next;
  logic   started;
  logic   accept;
  logic   timeout;

  // started keeps cmdReady low until the first edge after reset release
  assign cmdReady = started && (state == IDLE) && !memBusy;
  assign accept   = cmdValid && cmdReady;
  assign req      = (state == REQ);
  assign rspValid = (state == RESP);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wdog;
  logic             err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      if (accept) begin
        wdog <= '0;
        err  <= 1'b0;
      end else if (((state == ACK) || (state == BUSY)) && (wdog != CNT_MAX)) begin
        wdog <= wdog + 1'b1;
      end
      if (timeout) err <= 1'b1;
    end
  end

  // Leave ACK/BUSY on the edge where the counter reaches TIMEOUT_CYCLES
  assign timeout = ((state == ACK) || (state == BUSY)) && (wdog == CNT_LAST);
  assign rspErr  = err;
`else
  assign timeout = 1'b0;
  assign rspErr  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = REQ;
      REQ:  state_next = ACK;
      ACK: begin
        if (timeout)      state_next = RESP;
        else if (memBusy) state_next = BUSY;
      end
      BUSY: begin
        if (timeout || !memBusy) state_next = RESP;
      end
      RESP: if (rspReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started   <= 1'b0;
      memAddr   <= '0;
      memDataIn <= '0;
      wr        <= 1'b0;
      rspData   <= '0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        memAddr   <= cmdAddr;
        memDataIn <= cmdData;
        wr        <= cmdWr;
      end
      if (timeout) begin
        rspData <= '0;
      end else if ((state == BUSY) && !memBusy) begin
        rspData <= wr ? '0 : memDataOut;
      end
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: behavioural memory model plus expected-response queue.
// Timeout checks are compiled in when MEM_TIMEOUT_EN is defined.
module tb_mem_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmdValid, cmdReady, cmdWr;
  logic [31:0] cmdAddr;
  logic [7:0]  cmdData;
  logic        rspValid, rspReady, rspErr;
  logic [7:0]  rspData;
  logic [31:0] memAddr;
  logic [7:0]  memDataIn;
  logic        wr, req;
  logic        memBusy = 1'b0;
  logic [7:0]  memDataOut = 8'h00;

  mem_requester #(.MEM_ADDR_SIZE(32), .MEM_WORD_SIZE(8), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWr(cmdWr),
    .cmdAddr(cmdAddr), .cmdData(cmdData),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr),
    .memAddr(memAddr), .memDataIn(memDataIn), .wr(wr), .req(req),
    .memBusy(memBusy), .memDataOut(memDataOut)
  );

  always #5 clk = ~clk;

  // memory model: busy for lat cycles starting the edge after req is sampled
  logic [7:0] mem_arr [16];
  int  lat = 2;
  int  mcnt = 0;
  bit  stuck = 1'b0;

  always @(posedge clk) begin
    if (memBusy) begin
      if (mcnt <= 1) begin
        memBusy <= 1'b0;
        if (wr) mem_arr[memAddr[3:0]] <= memDataIn;
        else    memDataOut <= mem_arr[memAddr[3:0]];
      end
      mcnt <= mcnt - 1;
    end else if (req && !stuck) begin
      memBusy <= 1'b1;
      mcnt    <= lat;
    end
  end

  int req_count = 0;
  always @(negedge clk) if (req) req_count++;

  typedef struct packed {logic [7:0] data; logic err;} exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_addr;
  logic [7:0]  exp_wdata;
  logic        exp_wr;
  logic [7:0]  shadow [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [7:0] d,
                      input logic [7:0] exp_d, input logic exp_e);
    int n = 0;
    @(negedge clk);
    cmdValid = 1'b1; cmdWr = w; cmdAddr = a; cmdData = d;
    #1;
    while (!cmdReady && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("cmd_accept", {31'd0, cmdReady}, 32'd1);
    exp_addr = a; exp_wdata = d; exp_wr = w;
    sb_q.push_back('{data: exp_d, err: exp_e});
    @(posedge clk); #1;
    cmdValid = 1'b0;
  endtask

  task automatic get_rsp(input int hold);
    int   n = 0;
    int   rc;
    exp_t e;
    while (!rspValid && n < 200) begin
      if (memBusy) begin
        check("busy_addr",  memAddr, exp_addr);
        check("busy_wdata", {24'd0, memDataIn}, {24'd0, exp_wdata});
        check("busy_wr",    {31'd0, wr}, {31'd0, exp_wr});
      end
      @(negedge clk); n++;
    end
    check("rsp_seen", {31'd0, rspValid}, 32'd1);
    check("rsp_blocks_cmd", {31'd0, cmdReady}, 32'd0);
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
    rc = req_count;
    for (int k = 0; k < hold; k++) begin
      cmdValid = 1'b1; cmdWr = 1'b0; cmdAddr = 32'h1; // stray command must be ignored
      @(negedge clk);
      check("hold_valid", {31'd0, rspValid}, 32'd1);
      check("hold_data",  {24'd0, rspData}, {24'd0, e.data});
      check("hold_ready", {31'd0, cmdReady}, 32'd0);
    end
    cmdValid = 1'b0;
    if (hold > 0) check("hold_no_req", req_count, rc);
    rspReady = 1'b1;
    check("rsp_data", {24'd0, rspData}, {24'd0, e.data});
    check("rsp_err",  {31'd0, rspErr}, {31'd0, e.err});
    @(posedge clk); #1;
    rspReady = 1'b0;
    check("rsp_drop", {31'd0, rspValid}, 32'd0);
    check("ready_after_hs", {31'd0, cmdReady}, 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, cmdReady}, 32'd0);
    check({tag, "_rspv"},  {31'd0, rspValid}, 32'd0);
    check({tag, "_rspd"},  {24'd0, rspData}, 32'd0);
    check({tag, "_rspe"},  {31'd0, rspErr}, 32'd0);
    check({tag, "_req"},   {31'd0, req}, 32'd0);
    check({tag, "_wr"},    {31'd0, wr}, 32'd0);
    check({tag, "_addr"},  memAddr, 32'd0);
    check({tag, "_wdata"}, {24'd0, memDataIn}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   rc, n;
    bit   seen;
    logic [7:0] d;
    reset = 1'b0; cmdValid = 1'b0; cmdWr = 1'b0; cmdAddr = '0; cmdData = '0; rspReady = 1'b0;

    // reset values and first-edge ready
    @(negedge clk);
    check_zero_outputs("rst");
    reset = 1'b1;
    #1 check("ready_pre_edge", {31'd0, cmdReady}, 32'd0);
    @(posedge clk); #1;
    check("ready_post_edge", {31'd0, cmdReady}, 32'd1);

    // single write, latency 2
    lat = 2;
    rc = req_count;
    send(1'b1, 32'h3, 8'hA5, 8'h00, 1'b0);
    get_rsp(0);
    check("one_req_pulse", req_count - rc, 32'd1);
    check("wr_hold_addr", memAddr, 32'h3);

    // fill then read back
    for (int i = 0; i < 15; i++) begin
      d = 8'($urandom_range(0, 255));
      shadow[i] = d;
      lat = 1 + (i % 3);
      send(1'b1, 32'(i), d, 8'h00, 1'b0);
      get_rsp(0);
    end
    for (int i = 0; i < 15; i++) begin
      lat = 1 + ((i + 1) % 4);
      send(1'b0, 32'(i), 8'h00, shadow[i], 1'b0);
      get_rsp(0);
    end

    // response held off by rspReady
    lat = 3;
    send(1'b1, 32'h7, 8'h5A, 8'h00, 1'b0);
    get_rsp(0);
    send(1'b0, 32'h7, 8'h00, 8'h5A, 1'b0);
    get_rsp(5);

    // reset while memory busy
    lat = 20;
    send(1'b1, 32'h9, 8'h77, 8'h00, 1'b0);
    n = 0;
    while (!memBusy && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'd0, memBusy}, 32'd1);
    check("pre_rst_wr", {31'd0, wr}, 32'd1);
    reset = 1'b0;
    #1 check_zero_outputs("midrst");
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    n = 0; seen = 1'b0;
    while (memBusy && n < 100) begin
      if (cmdReady || rspValid) seen = 1'b1;
      @(negedge clk); n++;
    end
    check("blocked_while_busy", {31'd0, seen}, 32'd0);
    check("busy_released", {31'd0, memBusy}, 32'd0);
    check("ready_after_busy", {31'd0, cmdReady}, 32'd1);
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (rspValid) seen = 1'b1; end
    check("no_stale_rsp", {31'd0, seen}, 32'd0);

    // memory that never goes busy
    stuck = 1'b1;
`ifdef MEM_TIMEOUT_EN
    send(1'b0, 32'h2, 8'h00, 8'h00, 1'b1);
    @(posedge clk); #1;
    seen = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      if (rspValid) seen = 1'b1;
    end
    check("to_not_early", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;
    check("to_at_8", {31'd0, rspValid}, 32'd1);
    get_rsp(0);
`else
    send(1'b0, 32'h2, 8'h00, 8'h00, 1'b0);
    seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (rspValid || rspErr) seen = 1'b1;
    end
    check("stuck_no_rsp", {31'd0, seen}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
`endif
    stuck = 1'b0;

    check("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
